// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline stage register controller with skid entry, stall and flush (optional PIPE_STAGE_PERF_EN stall counter)
module pipe_stage_ctrl #(
    parameter int DLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DLEN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DLEN-1:0]  out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DLEN-1:0] r_main;
    logic [DLEN-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // in_ready decodes only the state register, so it has no path from out_ready
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY) && !stall;
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and entry-load decode; flush overrides everything and blocks all loads
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ST_HALF;
                    w_load_main_in = 1'b1;
                end
            end
            ST_HALF: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = ST_HALF;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // Main and skid entries; the skid only ever refills main, keeping FIFO order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_cnt_inc;

    assign w_cnt_inc = (r_state != ST_EMPTY) && !w_out_fire && !flush && (r_stall_cnt != {CNT_W{1'b1}});

    // Saturating count of cycles where held data did not move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - directed self-checking bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_ctrl #(.DLEN(32), .CNT_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] perf_val);
`ifdef PIPE_STAGE_PERF_EN
        return perf_val;
`else
        return (perf_val & 32'h0);
`endif
    endfunction

    initial begin
        // reset state
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // fill to FULL, then reset asynchronously mid-cycle
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
        step();
        check("fill_half_valid", out_valid, 1);
        in_data = 32'h2;
        step();
        check("fill_full_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        step();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
        step();
        check("post_rst_data", out_data, 32'hA5A5A5A5);
        check("post_rst_valid", out_valid, 1);

        // streaming 1..10
        for (int i = 1; i <= 10; i++) begin
            in_data = i;
            step();
            check("stream_data", out_data, i);
            check("stream_valid", out_valid, 1);
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", out_valid, 0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_data", out_data, 32'h11);
        check("bp_full_valid", out_valid, 1);
        step();
        check("bp_hold_data", out_data, 32'h11);
        check("bp_hold_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_second_data", out_data, 32'h22);
        check("bp_ready_back", in_ready, 1);
        check("bp_second_valid", out_valid, 1);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_cnt", stall_cnt, exp_cnt(32'd2));

        // stall for 3 cycles with main=0x33
        in_valid = 1'b1; in_data = 32'h33;
        step();
        in_valid = 1'b0; stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", out_valid, 0);
            step();
        end
        stall = 1'b0;
        #1;
        check("stall_release_valid", out_valid, 1);
        check("stall_release_data", out_data, 32'h33);
        check("stall_cnt3", stall_cnt, exp_cnt(32'd5));
        step();
        check("stall_drain", out_valid, 0);

        // flush from FULL with concurrent in_valid (0x44 never delivered)
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        step();
        in_data = 32'h66;
        step();
        check("flush_pre_full", in_ready, 0);
        flush = 1'b1; in_data = 32'h44;
        step();
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("flush_no_out", out_valid, 0);
        end

        // flush from HALF with a concurrent accept: main keeps old value
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step();
        flush = 1'b1; in_data = 32'h44;
        step();
        check("flush_half_valid", out_valid, 0);
        check("flush_half_data", out_data, 32'h77);
        flush = 1'b0; in_valid = 1'b0;

        // flush and stall together
        in_valid = 1'b1; in_data = 32'h88; out_ready = 1'b1;
        step();
        in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        #1;
        check("fs_valid", out_valid, 0);
        check("fs_ready", in_ready, 1);
        step();
        check("fs_still_empty", out_valid, 0);
        check("final_cnt", stall_cnt, exp_cnt(32'd6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
